// File: rtl/bus_mem_responder_if.sv
// CPU-side strobe/address bundle for the memory responder; the shared data_bus
// stays a plain inout on the responder so tri-state resolution stays at one level.
interface bus_mem_responder_if;
    logic [15:0] address_bus;
    logic        r;
    logic        w;

    modport master (output address_bus, output r, output w);
    modport slave  (input  address_bus, input  r, input  w);
endinterface

// File: rtl/bus_mem_responder.sv
// Zero-wait-state bus target: word RAM plus a 4-register MMIO window (IRQ pend/mask, timer).
// Read data is registered on every rising edge and driven while r is high; no backpressure.
module bus_mem_responder #(
    parameter int          DEPTH     = 2048,
    parameter logic [15:0] MMIO_BASE = 16'hFFF0
) (
    input  logic               clk,
    input  logic               reset,
    bus_mem_responder_if.slave bus,
    inout  wire  [15:0]        data_bus,
    input  logic [6:0]         irq_src,
    output logic [7:0]         interrupts,
    output logic               bus_error
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [16:0] RAM_TOP = 17'(DEPTH);

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_CNT  = 2'd2;
    localparam logic [1:0] REG_CMP  = 2'd3;

    logic [15:0]   mem [DEPTH];

    logic          ram_sel;
    logic          mmio_sel;
    logic          mapped;
    logic [1:0]    reg_off;
    logic [AW-1:0] ram_idx;
    logic [15:0]   mmio_rd;
    logic [15:0]   rd_nxt;
    logic [15:0]   rd_q;
    logic          sel_q;

    logic          wr_ram;
    logic          wr_pend;
    logic          wr_mask;
    logic          wr_cnt;
    logic          wr_cmp;

    logic [7:0]    pend;
    logic [7:0]    mask;
    logic [7:0]    pend_set;
    logic [7:0]    pend_clr;
    logic [6:0]    irq_src_d;
    logic [15:0]   tmr_cnt;
    logic [15:0]   tmr_cmp;
    logic          tmr_hit;

    assign ram_sel  = {1'b0, bus.address_bus} < RAM_TOP;
    assign mmio_sel = !ram_sel && (bus.address_bus[15:2] == MMIO_BASE[15:2]);
    assign mapped   = ram_sel | mmio_sel;
    assign reg_off  = bus.address_bus[1:0];
    assign ram_idx  = bus.address_bus[AW-1:0];

    assign wr_ram  = bus.w & ram_sel;
    assign wr_pend = bus.w & mmio_sel & (reg_off == REG_PEND);
    assign wr_mask = bus.w & mmio_sel & (reg_off == REG_MASK);
    assign wr_cnt  = bus.w & mmio_sel & (reg_off == REG_CNT);
    assign wr_cmp  = bus.w & mmio_sel & (reg_off == REG_CMP);

    // A counter load on the match edge replaces the old value, so that match never fires.
    assign tmr_hit  = (tmr_cnt == tmr_cmp) & ~wr_cnt;
    assign pend_set = {irq_src & ~irq_src_d, tmr_hit};
    assign pend_clr = wr_pend ? data_bus[7:0] : 8'h00;

    always_comb begin
        mmio_rd = 16'h0000;
        case (reg_off)
            REG_PEND: mmio_rd = {8'h00, pend};
            REG_MASK: mmio_rd = {8'h00, mask};
            REG_CNT:  mmio_rd = tmr_cnt;
            default:  mmio_rd = tmr_cmp;
        endcase
    end

    assign rd_nxt = ram_sel ? mem[ram_idx] : (mmio_sel ? mmio_rd : 16'h0000);

    // sel_q resets asynchronously, which releases the bus the moment reset asserts.
    assign data_bus = (bus.r && !bus.w && sel_q) ? rd_q : 16'hzzzz;

    always_ff @(posedge clk) begin
        if (wr_ram) begin
            mem[ram_idx] <= data_bus;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q       <= 16'h0000;
            sel_q      <= 1'b0;
            irq_src_d  <= 7'h00;
            pend       <= 8'h00;
            mask       <= 8'h00;
            tmr_cnt    <= 16'h0000;
            tmr_cmp    <= 16'hFFFF;
            interrupts <= 8'h00;
            bus_error  <= 1'b0;
        end else begin
            rd_q       <= rd_nxt;
            sel_q      <= mapped;
            irq_src_d  <= irq_src;
            // Set beats a simultaneous write-1-to-clear of the same bit.
            pend       <= (pend & ~pend_clr) | pend_set;
            interrupts <= pend & mask;
            tmr_cnt    <= wr_cnt ? data_bus : tmr_cnt + 16'd1;
            if (wr_mask) begin
                mask <= data_bus[7:0];
            end
            if (wr_cmp) begin
                tmr_cmp <= data_bus;
            end
            if ((bus.r | bus.w) & ~mapped) begin
                bus_error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Bus responder (target) for the 16-bit CPU bus: address_bus, data_bus, r and w.
- Contains a word-addressed RAM and a small memory-mapped I/O window.
- The I/O window holds an interrupt controller (pending/mask) and a free-running compare timer.
- Drives the CPU's 8-bit interrupts input and returns read data within the CPU's fixed fetch/load timing, with no wait states.

Parameters:
- DEPTH, 2048: RAM words, occupying addresses 0 .. DEPTH-1. Must be a power of two, at most 32768.
- MMIO_BASE, 16'hFFF0: base of the 4-word I/O window, 16-word aligned.

Ports:
- clk  input  1  system clock, rising-edge logic only
- reset  input  1  asynchronous, active-low reset
- address_bus  input  16  word address from CPU
- data_bus  inout  16  shared data bus; driven by this block only during a selected read
- r  input  1  read strobe
- w  input  1  write strobe; CPU drives data_bus while high
- irq_src  input  7  external interrupt sources, bits 7..1; synchronous to clk, rising-edge detected
- interrupts  output  8  pending & mask, registered
- bus_error  output  1  sticky flag: access to an unmapped address

Behaviour:
- Address decode
  - RAM select: address_bus < DEPTH.
  - MMIO select: address_bus[15:2] == MMIO_BASE[15:2].
  - Any other address is unmapped.
- Read path
  - Every rising edge registers rd_q from the current address_bus, whether or not r is high:
    - RAM word at that address, or
    - MMIO register value, or
    - 16'h0000 if unmapped.
  - data_bus = rd_q while r && !w && sel_q, where sel_q is the registered mapped flag; otherwise high-Z.
  - Because the CPU sets the address on a falling edge and samples in the following r-high phase, read latency is 0 cycles from r.
- Write path
  - Commits on the rising edge where w is sampled high, using the address_bus and data_bus values present at that edge.
  - r and w both high: treated as a write; data_bus is not driven.
- Unmapped access
  - Applies to a rising edge with r or w high and an unmapped address.
  - Sets bus_error, which stays set until reset.
  - Writes are dropped.
- MMIO registers (offset from MMIO_BASE)
  - 0 IRQ_PEND
    - Read returns {8'h00, pend}.
    - Write: bits set in data[7:0] clear the corresponding pend bits (write-1-to-clear).
  - 1 IRQ_MASK: read/write, low 8 bits; upper bits read 0.
  - 2 TIMER_CNT
    - Increments by 1 every clock, wrapping FFFF -> 0000.
    - Write loads the written value; the count continues from it on the next clock.
  - 3 TIMER_CMP: read/write, 16 bits.
- Pending bits
  - pend[k] for k = 7..1 sets on the rising edge after irq_src[k-1] is seen going 0 -> 1. irq_src_d is registered.
  - pend[0] sets on the rising edge after TIMER_CNT == TIMER_CMP.
  - A set event and a W1C clear of the same bit on the same edge: set wins.
  - A TIMER_CNT write on the same edge as a match: the write wins, and the match of the old value is suppressed.
- interrupts <= pend & mask, registered, so it lags a pend update by 1 cycle.
- Reset (asserted at any time, including mid-transfer)
  - data_bus released immediately.
  - rd_q = 0, sel_q = 0, pend = 0, mask = 0, TIMER_CNT = 0, TIMER_CMP = 16'hFFFF, interrupts = 0, bus_error = 0, irq_src_d = 0.
  - RAM contents are not cleared.
  - A write in flight when reset asserts is lost.
- RAM: single port, inferred. Index is address_bus[log2(DEPTH)-1:0] after the select check.

Test Plan:
- RAM write/read:
  - Stimulus: w=1 at addr 16'h0010 with data 16'hBEEF, then r=1 at 16'h0010.
  - Required: data_bus = 16'hBEEF during r; data_bus is Z whenever r=0.
- Unmapped access:
  - Stimulus: r=1 at 16'h9000 (DEPTH=2048).
  - Required: data_bus is Z; bus_error goes to 1 and stays 1 through later good accesses until reset.
- Interrupt edge, mask and W1C:
  - Step 1: write IRQ_MASK = 16'h0004, then pulse irq_src[1]. Required: interrupts = 8'h04 two edges after the pulse.
  - Step 2: write IRQ_PEND = 16'h0004. Required: interrupts = 0 on the following cycle.
  - Step 3: write the W1C on the same edge as a new irq_src[1] edge. Required: pend[2] stays 1.
- Timer:
  - Stimulus: TIMER_CMP = 16'h0005, TIMER_CNT = 16'h0000, mask = 8'h01.
  - Required: pend[0] sets 6 edges after the count write; reading TIMER_CNT afterwards shows the count advancing.
  - Wrap: load 16'hFFFF. Required: the next cycle reads 16'h0000.
- Reset mid-operation:
  - Stimulus: assert reset while r=1 and data_bus is driven.
  - Required: data_bus goes Z asynchronously; pend, mask and interrupts go to 0; TIMER_CMP reads 16'hFFFF; RAM word 16'h0010 still reads 16'hBEEF.
